// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: drives an init vector, then LFSR patterns into the CUT,
// compacts CUT responses in a MISR and checks the final signature.
module bist_seq_ctrl #(
    parameter int unsigned PI_W = 3,
    parameter int unsigned PO_W = 6,
    parameter int unsigned N_PAT = 256,
    parameter int unsigned INIT_CYC = 4,
    parameter logic [PI_W-1:0] INIT_VEC = PI_W'(3'b001),
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            START,
    input  logic            ABORT,
    input  logic [15:0]     GOLDEN,
    input  logic [PO_W-1:0] PO,
    output logic [PI_W-1:0] PI,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [15:0]     SIG,
    output logic [15:0]     CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    localparam logic [7:0]  INIT_LAST = 8'(INIT_CYC - 1);
    localparam logic [15:0] PAT_LAST  = 16'(N_PAT - 1);

    logic [1:0]  state;
    logic [7:0]  icnt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] sig_nxt;
    logic [15:0] po_x;

    // x^16 + x^14 + x^13 + x^11 + 1, shared by LFSR and MISR
    function automatic logic fb(input logic [15:0] x);
        return x[15] ^ x[13] ^ x[12] ^ x[10];
    endfunction

    assign po_x     = 16'(PO);
    assign lfsr_nxt = {lfsr[14:0], fb(lfsr)};
    assign sig_nxt  = {SIG[14:0], fb(SIG)} ^ po_x;

    // Sequencer state, pattern generator, compactor and result flags
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
            icnt  <= 8'd0;
            lfsr  <= SEED;
            PI    <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
            SIG   <= 16'd0;
            CNT   <= 16'd0;
        end else if (ABORT && state != S_IDLE) begin
            state <= S_IDLE;
            PI    <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START && !ABORT) begin
                        state <= S_INIT;
                        icnt  <= 8'd0;
                        lfsr  <= SEED;
                        PI    <= INIT_VEC;
                        BUSY  <= 1'b1;
                        DONE  <= 1'b0;
                        PASS  <= 1'b0;
                        SIG   <= 16'd0;
                        CNT   <= 16'd0;
                    end
                end
                S_INIT: begin
                    if (icnt == INIT_LAST) begin
                        PI    <= lfsr[PI_W-1:0];
                        state <= S_RUN;
                    end else begin
                        icnt <= icnt + 8'd1;
                    end
                end
                S_RUN: begin
                    SIG  <= sig_nxt;
                    lfsr <= lfsr_nxt;
                    CNT  <= CNT + 16'd1;
                    if (CNT == PAT_LAST) begin
                        PI    <= '0;
                        state <= S_CHECK;
                    end else begin
                        PI <= lfsr_nxt[PI_W-1:0];
                    end
                end
                S_CHECK: begin
                    PASS  <= (SIG == GOLDEN);
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench for bist_seq_ctrl: default-size instance plus a
// two-pattern instance for signature arithmetic and back-to-back runs.
module tb_bist_seq_ctrl;

    logic        CK;
    logic        RN;

    logic        start, abort;
    logic [15:0] golden;
    logic [5:0]  po;
    logic [2:0]  pi;
    logic        busy, done, pass;
    logic [15:0] sig, cnt;

    logic        start2, abort2;
    logic [15:0] golden2;
    logic [5:0]  po2;
    logic [2:0]  pi2;
    logic        busy2, done2, pass2;
    logic [15:0] sig2, cnt2;

    int checks;
    int failures;

    typedef struct {
        logic [5:0]  po;
        logic [15:0] golden;
        logic [15:0] sig;
        logic        pass;
    } vec_t;

    vec_t tv[6];
    logic [2:0] exp_pi[7];

    bist_seq_ctrl dut (
        .CK(CK), .RN(RN), .START(start), .ABORT(abort),
        .GOLDEN(golden), .PO(po), .PI(pi), .BUSY(busy),
        .DONE(done), .PASS(pass), .SIG(sig), .CNT(cnt)
    );

    bist_seq_ctrl #(.N_PAT(2)) dut2 (
        .CK(CK), .RN(RN), .START(start2), .ABORT(abort2),
        .GOLDEN(golden2), .PO(po2), .PI(pi2), .BUSY(busy2),
        .DONE(done2), .PASS(pass2), .SIG(sig2), .CNT(cnt2)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // START pulse on dut2, wait for DONE, return edges after acceptance
    task automatic run2(input logic [5:0] p, input logic [15:0] g,
                        output int n);
        @(negedge CK);
        po2 = p;
        golden2 = g;
        start2 = 1'b1;
        @(negedge CK);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge CK);
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        checks = 0;
        failures = 0;

        tv[0] = '{po: 6'h3F, golden: 16'h0041, sig: 16'h0041, pass: 1'b1};
        tv[1] = '{po: 6'h3F, golden: 16'h0042, sig: 16'h0041, pass: 1'b0};
        tv[2] = '{po: 6'h00, golden: 16'h0000, sig: 16'h0000, pass: 1'b1};
        tv[3] = '{po: 6'h01, golden: 16'h0003, sig: 16'h0003, pass: 1'b1};
        tv[4] = '{po: 6'h2A, golden: 16'h007E, sig: 16'h007E, pass: 1'b1};
        tv[5] = '{po: 6'h15, golden: 16'h0000, sig: 16'h003F, pass: 1'b0};
        exp_pi = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b111};

        RN = 1'b0;
        start = 0; abort = 0; golden = 0; po = 0;
        start2 = 0; abort2 = 0; golden2 = 0; po2 = 0;
        #2;
        chk("rst_pi", 32'(pi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sig", 32'(sig), 0);
        chk("rst_cnt", 32'(cnt), 0);
        @(negedge CK);
        RN = 1'b1;

        // two-pattern signature table
        for (int i = 0; i < 6; i++) begin
            run2(tv[i].po, tv[i].golden, n);
            chk($sformatf("tv%0d_lat", i), 32'(n), 7);
            chk($sformatf("tv%0d_sig", i), 32'(sig2), 32'(tv[i].sig));
            chk($sformatf("tv%0d_pass", i), 32'(pass2), 32'(tv[i].pass));
            chk($sformatf("tv%0d_cnt", i), 32'(cnt2), 2);
            chk($sformatf("tv%0d_busy", i), 32'(busy2), 0);
        end

        // back-to-back with START held high
        @(negedge CK);
        po2 = 6'h3F;
        golden2 = 16'h0041;
        start2 = 1'b1;
        @(negedge CK);
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge CK);
            n++;
        end
        chk("b2b_lat1", 32'(n), 7);
        chk("b2b_sig1", 32'(sig2), 32'h41);
        @(negedge CK);
        chk("b2b_done_clr", 32'(done2), 0);
        chk("b2b_busy2", 32'(busy2), 1);
        chk("b2b_cnt_clr", 32'(cnt2), 0);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge CK);
            n++;
        end
        chk("b2b_lat2", 32'(n), 7);
        chk("b2b_sig2", 32'(sig2), 32'h41);
        chk("b2b_pass2", 32'(pass2), 1);

        // default instance: pattern order and zero-response run
        @(negedge CK);
        po = 6'h00;
        golden = 16'h0000;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        bad = 0;
        for (int k = 0; k <= 261; k++) begin
            if (k < 7)
                chk($sformatf("pi_k%0d", k), 32'(pi), 32'(exp_pi[k]));
            if (k < 261) begin
                if (busy !== 1'b1 || done !== 1'b0)
                    bad++;
                @(negedge CK);
            end
        end
        chk("busy_window", 32'(bad), 0);
        chk("zr_done", 32'(done), 1);
        chk("zr_busy", 32'(busy), 0);
        chk("zr_pass", 32'(pass), 1);
        chk("zr_sig", 32'(sig), 0);
        chk("zr_cnt", 32'(cnt), 256);
        chk("zr_pi", 32'(pi), 0);

        // abort during RUN with CNT=10
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (14) @(negedge CK);
        chk("ab_pre_cnt", 32'(cnt), 10);
        chk("ab_pre_done", 32'(done), 0);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_pass", 32'(pass), 0);
        chk("ab_pi", 32'(pi), 0);
        chk("ab_cnt", 32'(cnt), 10);
        repeat (3) @(negedge CK);
        chk("ab_cnt_hold", 32'(cnt), 10);

        // START and ABORT together in IDLE
        start = 1'b1;
        abort = 1'b1;
        repeat (3) @(negedge CK);
        chk("sa_busy", 32'(busy), 0);
        chk("sa_cnt", 32'(cnt), 10);
        chk("sa_pi", 32'(pi), 0);
        start = 1'b0;
        abort = 1'b0;

        // asynchronous reset mid-RUN
        po = 6'h15;
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (24) @(negedge CK);
        chk("rr_pre_cnt", 32'(cnt), 20);
        chk("rr_pre_busy", 32'(busy), 1);
        #2;
        RN = 1'b0;
        #1;
        chk("rr_pi", 32'(pi), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_done", 32'(done), 0);
        chk("rr_sig", 32'(sig), 0);
        chk("rr_cnt", 32'(cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
